// File: rtl/fetch_stage_if.sv
// Bundle of fetch-stage signals: hazard-unit stalls, ID redirect, instruction
// memory port, IF/ID outputs and performance counters.
interface fetch_stage_if #(
    parameter int CNT_W = 32
);
    logic             stallF;
    logic             stallD;
    logic             pcsrcD;
    logic             jumpD;
    logic [31:0]      pcbranchD;
    logic [31:0]      pcjumpD;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_rdata;
    logic [31:0]      instrD;
    logic [31:0]      pcplus4D;
    logic             validD;
    logic             misalignF;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Core side: hazard unit, ID stage and instruction memory.
    modport master (
        output stallF, stallD, pcsrcD, jumpD, pcbranchD, pcjumpD, imem_rdata,
        input  imem_addr, instrD, pcplus4D, validD, misalignF, stall_cnt, flush_cnt
    );

    modport slave (
        input  stallF, stallD, pcsrcD, jumpD, pcbranchD, pcjumpD, imem_rdata,
        output imem_addr, instrD, pcplus4D, validD, misalignF, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register: PC, PC+4, branch/jump redirect, stall hold, flush bubble.
// Optional FETCH_PERF_CNT_EN adds saturating stall/flush counters; otherwise they read 0.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    fetch_stage_if.slave  bus
);
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pcplus4;
    logic        r_valid;
    logic        r_misalign;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pcplus4;

    // Jump wins over branch when ID presents both.
    assign w_redirect = bus.jumpD | bus.pcsrcD;
    assign w_target   = bus.jumpD ? bus.pcjumpD : bus.pcbranchD;
    assign w_pcplus4  = r_pc + 32'd4;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else if (!bus.stallF) begin
            r_pc <= w_redirect ? {w_target[31:2], 2'b00} : w_pcplus4;
            if (w_redirect && (w_target[1:0] != 2'b00))
                r_misalign <= 1'b1;
        end
    end

    // Stall beats flush: a held ID stage keeps its instruction even if a redirect is pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_instr   <= NOP_INSTR;
            r_pcplus4 <= 32'h0000_0000;
            r_valid   <= 1'b0;
        end else if (!bus.stallD) begin
            if (w_redirect) begin
                r_instr   <= NOP_INSTR;
                r_pcplus4 <= 32'h0000_0000;
                r_valid   <= 1'b0;
            end else begin
                r_instr   <= bus.imem_rdata;
                r_pcplus4 <= w_pcplus4;
                r_valid   <= 1'b1;
            end
        end
    end

    assign bus.imem_addr = r_pc;
    assign bus.instrD    = r_instr;
    assign bus.pcplus4D  = r_pcplus4;
    assign bus.validD    = r_valid;
    assign bus.misalignF = r_misalign;

`ifdef FETCH_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (bus.stallF && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (!bus.stallD && w_redirect && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
`else
    assign bus.stall_cnt = {CNT_W{1'b0}};
    assign bus.flush_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory returns address + 0x1000_0000.
module tb_fetch_stage;
`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    fetch_stage_if #(.CNT_W(32)) bus ();

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000),
        .CNT_W     (32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    assign bus.imem_rdata = bus.imem_addr + 32'h1000_0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] addr,
                              input logic [31:0] instr, input logic [31:0] pc4,
                              input logic valid);
        check({tag, ".addr"},  bus.imem_addr, addr);
        check({tag, ".instr"}, bus.instrD,    instr);
        check({tag, ".pc4"},   bus.pcplus4D,  pc4);
        check({tag, ".valid"}, {31'd0, bus.validD}, {31'd0, valid});
    endtask

    initial begin
        bus.stallF    = 1'b0;
        bus.stallD    = 1'b0;
        bus.pcsrcD    = 1'b0;
        bus.jumpD     = 1'b0;
        bus.pcbranchD = 32'h0;
        bus.pcjumpD   = 32'h0;

        #2;
        check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        check("reset.mis", {31'd0, bus.misalignF}, 32'd0);
        check("reset.scnt", bus.stall_cnt, 32'd0);
        check("reset.fcnt", bus.flush_cnt, 32'd0);
        #1 reset_n = 1'b1;

        // Sequential fetch: instrD lags imem_addr by one cycle.
        step(); check_ifid("seq1", 32'h4,  32'h1000_0000, 32'h4,  1'b1);
        step(); check_ifid("seq2", 32'h8,  32'h1000_0004, 32'h8,  1'b1);
        step(); check_ifid("seq3", 32'hC,  32'h1000_0008, 32'hC,  1'b1);
        step(); check_ifid("seq4", 32'h10, 32'h1000_000C, 32'h10, 1'b1);

        // Full stall for three cycles.
        bus.stallF = 1'b1; bus.stallD = 1'b1;
        step(); check_ifid("stall1", 32'h10, 32'h1000_000C, 32'h10, 1'b1);
        step(); step();
        check_ifid("stall3", 32'h10, 32'h1000_000C, 32'h10, 1'b1);
        check("stall3.scnt", bus.stall_cnt, PERF ? 32'd3 : 32'd0);
        bus.stallF = 1'b0; bus.stallD = 1'b0;
        step(); check_ifid("resume", 32'h14, 32'h1000_0010, 32'h14, 1'b1);

        // Branch redirect inserts a bubble.
        bus.pcsrcD = 1'b1; bus.pcbranchD = 32'h40;
        step(); check_ifid("br", 32'h40, 32'h0, 32'h0, 1'b0);
        check("br.fcnt", bus.flush_cnt, PERF ? 32'd1 : 32'd0);
        bus.pcsrcD = 1'b0;
        step(); check_ifid("br.next", 32'h44, 32'h1000_0040, 32'h44, 1'b1);

        // Jump and branch together: jump wins.
        bus.jumpD = 1'b1; bus.pcjumpD = 32'h80; bus.pcsrcD = 1'b1; bus.pcbranchD = 32'h40;
        step(); check_ifid("jmp", 32'h80, 32'h0, 32'h0, 1'b0);
        check("jmp.mis", {31'd0, bus.misalignF}, 32'd0);

        // Misaligned branch target: PC aligned, misalignF sticky.
        bus.jumpD = 1'b0; bus.pcbranchD = 32'h42;
        step(); check("mis.addr", bus.imem_addr, 32'h40);
        check("mis.flag", {31'd0, bus.misalignF}, 32'd1);
        check("mis.fcnt", bus.flush_cnt, PERF ? 32'd3 : 32'd0);
        bus.pcsrcD = 1'b0;
        step(); check_ifid("mis.next", 32'h44, 32'h1000_0040, 32'h44, 1'b1);
        check("mis.sticky", {31'd0, bus.misalignF}, 32'd1);

        // Redirect ignored under full stall.
        bus.stallF = 1'b1; bus.stallD = 1'b1; bus.pcsrcD = 1'b1; bus.pcbranchD = 32'h100;
        step(); check_ifid("stbr", 32'h44, 32'h1000_0040, 32'h44, 1'b1);
        check("stbr.fcnt", bus.flush_cnt, PERF ? 32'd3 : 32'd0);
        check("stbr.scnt", bus.stall_cnt, PERF ? 32'd4 : 32'd0);
        bus.pcsrcD = 1'b0;

        // stallF=0, stallD=1: PC advances, fetched word dropped.
        bus.stallF = 1'b0;
        step(); check_ifid("drop", 32'h48, 32'h1000_0040, 32'h44, 1'b1);
        bus.stallD = 1'b0;
        step(); check_ifid("drop.next", 32'h4C, 32'h1000_0048, 32'h4C, 1'b1);

        // PC wrap at top of address space.
        bus.jumpD = 1'b1; bus.pcjumpD = 32'hFFFF_FFFC;
        step(); check_ifid("wrap.jmp", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        check("wrap.fcnt", bus.flush_cnt, PERF ? 32'd4 : 32'd0);
        bus.jumpD = 1'b0;
        step(); check_ifid("wrap", 32'h0, 32'h0FFF_FFFC, 32'h0, 1'b1);

        // Asynchronous reset in the middle of a stall.
        bus.stallF = 1'b1; bus.stallD = 1'b1;
        step();
        #2 reset_n = 1'b0;
        #1;
        check_ifid("arst", 32'h0, 32'h0, 32'h0, 1'b0);
        check("arst.mis", {31'd0, bus.misalignF}, 32'd0);
        check("arst.scnt", bus.stall_cnt, 32'd0);
        check("arst.fcnt", bus.flush_cnt, 32'd0);
        bus.stallF = 1'b0; bus.stallD = 1'b0;
        #2 reset_n = 1'b1;
        step(); check_ifid("rel", 32'h4, 32'h1000_0000, 32'h4, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
